msix_intr_sched: RTL and testbench
==================================

Name: msix_intr_sched

Overview:
- Hardware MSI-X message generator between device interrupt sources and the host memory write path.
- Latches per-vector interrupt requests into a pending-bit array and keeps a programmable vector table (address, data, mask).
- Round-robin arbitrates among unmasked pending vectors.
- Issues one DW memory write per message on a valid/ready port; the host memory model detects that write as an MSI-X interrupt.

Parameters:
- NUM_VEC, 8, number of MSI-X vectors / requesters (2..32)
- IDX_W, $clog2(NUM_VEC), vector index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- intr_req  in  NUM_VEC  per-vector request pulses, sampled every cycle
- msix_en  in  1  global MSI-X enable
- func_mask  in  1  function mask; blocks all sends when high
- cfg_wr_en  in  1  vector-table write strobe
- cfg_idx  in  IDX_W  vector-table entry index
- cfg_sel  in  2  0=addr_lo, 1=addr_hi, 2=data, 3=ctrl (bit0 = mask)
- cfg_wdata  in  32  write data
- wr_valid  out  1  message write valid
- wr_ready  in  1  host write path ready
- wr_addr  out  64  message address, DW aligned
- wr_data  out  32  message data
- wr_vec  out  IDX_W  vector index of the current message
- pba  out  NUM_VEC  pending-bit array
- msg_cnt  out  16  messages sent, wraps

Behaviour:
- Reset (sync; rst wins over every other event):
  - pba=0, all table addr/data=0, all masks=1.
  - wr_valid=0, wr_addr=0, wr_data=0, wr_vec=0, msg_cnt=0.
  - RR pointer=0, state=IDLE.
  - Reset during SEND drops the message without a handshake.
- Pending:
  - pba[i] sets on the clock edge where intr_req[i]=1.
  - pba[i] clears on the edge where vector i's message handshakes (wr_valid & wr_ready).
  - If a set and a clear hit pba[i] on the same edge, set wins; the vector stays pending and is sent again later.
  - Repeated requests while already pending merge into one message.
- Eligible vector i: pba[i] & ~mask[i] & msix_en & ~func_mask.
  - Masked or disabled vectors stay pending indefinitely and are sent once unmasked/enabled.
- FSM with states IDLE and SEND:
  - IDLE: if any vector is eligible, the RR arbiter grants one. On the same edge, wr_addr/wr_data/wr_vec are snapshotted from the table, wr_valid goes to 1, and the FSM moves to SEND.
  - SEND: wr_valid, wr_addr, wr_data and wr_vec are held stable until wr_ready=1. On the handshake edge: wr_valid goes to 0, pba[vec] clears, msg_cnt increments, the RR pointer moves to vec+1 (mod NUM_VEC), and the FSM returns to IDLE.
  - Minimum gap between messages is one IDLE cycle, so throughput is at most one message per 2 cycles.
- Latency:
  - intr_req high in cycle 0 gives pba set in cycle 1 and wr_valid=1 in cycle 2 (idle scheduler, ready path).
- Round-robin:
  - Search starts at the RR pointer and moves upward with wrap; the first eligible vector wins.
  - After reset the pointer is 0, so vector 0 has highest priority.
- Committed messages:
  - A message in SEND always completes, even if mask, msix_en, func_mask or the table entry changes meanwhile; its outputs are the snapshot.
- Table writes:
  - Take effect on the next edge.
  - addr_lo bits [1:0] are forced to 0.
  - ctrl writes only bit0.
  - Writes with cfg_idx >= NUM_VEC are ignored.
- msg_cnt wraps from 0xFFFF to 0x0000.

Decomposition:
- Package msix_pkg holds:
  - cfg_sel encoding constants (CFG_ADDR_LO, CFG_ADDR_HI, CFG_DATA, CFG_CTRL)
  - msix_entry_t struct (addr 64, data 32, mask 1)
  - FSM state enum (IDLE, SEND)
- Sub-module msix_rr_arb (NUM_VEC):
  - Inputs: eligible vector, RR pointer.
  - Outputs: grant_valid, grant_idx.
  - Purely combinational. The pointer register lives in the parent.

Test Plan:
- Basic send: program vec 3 with addr=0x0000_0001_0000_1000, data=0xA5A5_0003, mask=0, msix_en=1. Pulse intr_req[3] in cycle 0 -> wr_valid=1 in cycle 2 with wr_addr=0x1_0000_1000, wr_data=0xA5A5_0003, wr_vec=3; pba[3] clears after the handshake; msg_cnt=1.
- Round-robin: vectors 0, 2 and 5 unmasked and requested in the same cycle, wr_ready held 1 -> messages issue in order 0, 2, 5 with one idle cycle between each.
- Mask: vec 1 masked, intr_req[1] pulsed -> pba[1]=1 and no wr_valid for 20 cycles. Write ctrl=0 -> message issues 2 cycles later.
- Backpressure and snapshot: wr_ready=0 for 10 cycles while the data of the in-flight vector is rewritten to 0xDEAD -> wr_addr/wr_data stay at the original values for all 10 cycles. Re-pulsing intr_req on the same vector in the handshake cycle -> pba stays 1 and a second message follows.
- Alignment and range: write addr_lo=0x1003 -> wr_addr[31:0]=0x1000. A cfg write with cfg_idx=NUM_VEC changes no table entry.
- Reset mid-SEND: assert rst while wr_valid=1 -> next cycle wr_valid=0, pba=0, msg_cnt=0, all masks read back as 1.

Source files
------------

// File: rtl/msix_pkg.sv
// Shared types for the MSI-X scheduler: config select codes, vector-table entry, FSM states.
package msix_pkg;

    localparam logic [1:0] CFG_ADDR_LO = 2'd0;
    localparam logic [1:0] CFG_ADDR_HI = 2'd1;
    localparam logic [1:0] CFG_DATA    = 2'd2;
    localparam logic [1:0] CFG_CTRL    = 2'd3;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
        logic        mask;
    } msix_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/msix_rr_arb.sv
// Round-robin pick of the first eligible vector at or above ptr_i, wrapping.
// Purely combinational; zero latency, no backpressure.
module msix_rr_arb #(
    parameter int NUM_VEC = 8,
    parameter int IDX_W   = $clog2(NUM_VEC)
) (
    input  logic [NUM_VEC-1:0] elig_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        // Scan from farthest to nearest so the closest eligible vector is assigned last.
        for (int k = NUM_VEC - 1; k >= 0; k--) begin
            if (elig_i[(int'(ptr_i) + k) % NUM_VEC]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_VEC);
            end
        end
    end

endmodule

// File: rtl/msix_intr_sched.sv
// MSI-X message generator: pending bits, vector table, RR arbitration, one DW write per message.
// Request to wr_valid is 2 cycles; a granted message holds its snapshot until wr_ready.
module msix_intr_sched
    import msix_pkg::*;
#(
    parameter int NUM_VEC = 8,
    parameter int IDX_W   = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_VEC-1:0] intr_req,
    input  logic               msix_en,
    input  logic               func_mask,
    input  logic               cfg_wr_en,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [1:0]         cfg_sel,
    input  logic [31:0]        cfg_wdata,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [63:0]        wr_addr,
    output logic [31:0]        wr_data,
    output logic [IDX_W-1:0]   wr_vec,
    output logic [NUM_VEC-1:0] pba,
    output logic [15:0]        msg_cnt
);

    msix_entry_t        tbl_q [NUM_VEC];
    state_t             state_q, state_d;
    logic [NUM_VEC-1:0] pba_q, pba_d, clr, mask_vec, elig;
    logic [IDX_W-1:0]   ptr_q, ptr_d, vec_q, vec_d, gnt_idx;
    logic               gnt_vld;
    logic               vld_q, vld_d;
    logic [63:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [15:0]        cnt_q, cnt_d;

    always_comb begin
        mask_vec = '0;
        for (int i = 0; i < NUM_VEC; i++) begin
            mask_vec[i] = tbl_q[i].mask;
        end
        elig = pba_q & ~mask_vec & {NUM_VEC{msix_en & ~func_mask}};
    end

    msix_rr_arb #(.NUM_VEC(NUM_VEC), .IDX_W(IDX_W)) u_arb (
        .elig_i        (elig),
        .ptr_i         (ptr_q),
        .grant_valid_o (gnt_vld),
        .grant_idx_o   (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        addr_d  = addr_q;
        data_d  = data_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    addr_d  = tbl_q[gnt_idx].addr;
                    data_d  = tbl_q[gnt_idx].data;
                    vec_d   = gnt_idx;
                    vld_d   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (wr_ready) begin
                    vld_d      = 1'b0;
                    clr[vec_q] = 1'b1;
                    cnt_d      = cnt_q + 16'd1;
                    ptr_d      = (vec_q == IDX_W'(NUM_VEC - 1)) ? '0 : vec_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new request on the handshake edge must survive the clear.
        pba_d = (pba_q & ~clr) | intr_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vld_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            pba_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            pba_q   <= pba_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                tbl_q[i] <= '{addr: 64'd0, data: 32'd0, mask: 1'b1};
            end
        end else if (cfg_wr_en && (int'(cfg_idx) < NUM_VEC)) begin
            case (cfg_sel)
                CFG_ADDR_LO: tbl_q[cfg_idx].addr[31:0]  <= {cfg_wdata[31:2], 2'b00};
                CFG_ADDR_HI: tbl_q[cfg_idx].addr[63:32] <= cfg_wdata;
                CFG_DATA:    tbl_q[cfg_idx].data        <= cfg_wdata;
                default:     tbl_q[cfg_idx].mask        <= cfg_wdata[0];
            endcase
        end
    end

    assign wr_valid = vld_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign wr_vec   = vec_q;
    assign pba      = pba_q;
    assign msg_cnt  = cnt_q;

endmodule

// File: tb/tb_msix_intr_sched.sv
// Directed bench for msix_intr_sched with six vectors so an out-of-range cfg_idx is encodable.
module tb_msix_intr_sched;
    import msix_pkg::*;

    localparam int NV = 6;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NV-1:0] intr_req = '0;
    logic          msix_en = 1'b0;
    logic          func_mask = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [1:0]    cfg_sel = '0;
    logic [31:0]   cfg_wdata = '0;
    logic          wr_valid;
    logic          wr_ready = 1'b0;
    logic [63:0]   wr_addr;
    logic [31:0]   wr_data;
    logic [IW-1:0] wr_vec;
    logic [NV-1:0] pba;
    logic [15:0]   msg_cnt;

    int n_cmp = 0;
    int n_err = 0;

    msix_intr_sched #(.NUM_VEC(NV), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .intr_req  (intr_req),
        .msix_en   (msix_en),
        .func_mask (func_mask),
        .cfg_wr_en (cfg_wr_en),
        .cfg_idx   (cfg_idx),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_vec    (wr_vec),
        .pba       (pba),
        .msg_cnt   (msg_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg_wr(input int idx, input logic [1:0] sel, input logic [31:0] wdata);
        cfg_wr_en = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_sel   = sel;
        cfg_wdata = wdata;
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse(input logic [NV-1:0] req);
        intr_req = req;
        step();
        intr_req = '0;
    endtask

    logic [5:0] rr_vld;
    int         rr_vec [6];
    int         seen;

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        chk("rst_valid", wr_valid, 0);
        chk("rst_pba", pba, 0);
        chk("rst_cnt", msg_cnt, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        step();
        rst = 1'b0;

        // Basic send on vector 3
        cfg_wr(3, CFG_ADDR_LO, 32'h0000_1000);
        cfg_wr(3, CFG_ADDR_HI, 32'h0000_0001);
        cfg_wr(3, CFG_DATA, 32'hA5A5_0003);
        cfg_wr(3, CFG_CTRL, 32'h0);
        msix_en  = 1'b1;
        wr_ready = 1'b1;
        pulse(6'b001000);
        chk("basic_pba_c1", pba, 6'b001000);
        chk("basic_vld_c1", wr_valid, 0);
        step();
        chk("basic_vld_c2", wr_valid, 1);
        chk("basic_addr", wr_addr, 64'h0000_0001_0000_1000);
        chk("basic_data", wr_data, 32'hA5A5_0003);
        chk("basic_vec", wr_vec, 3);
        step();
        chk("basic_vld_c3", wr_valid, 0);
        chk("basic_pba_c3", pba, 0);
        chk("basic_cnt", msg_cnt, 1);

        // Round-robin 0, 2, 5 from a fresh pointer
        do_reset();
        cfg_wr(0, CFG_DATA, 32'h100); cfg_wr(0, CFG_CTRL, 0);
        cfg_wr(2, CFG_DATA, 32'h102); cfg_wr(2, CFG_CTRL, 0);
        cfg_wr(5, CFG_DATA, 32'h105); cfg_wr(5, CFG_CTRL, 0);
        rr_vld = 6'b010101;
        rr_vec = '{0, 0, 2, 0, 5, 0};
        pulse(6'b100101);
        chk("rr_pba", pba, 6'b100101);
        step();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_vld%0d", i), wr_valid, rr_vld[i]);
            if (rr_vld[i]) begin
                chk($sformatf("rr_vec%0d", i), wr_vec, rr_vec[i]);
                chk($sformatf("rr_data%0d", i), wr_data, 32'h100 + rr_vec[i]);
            end
            step();
        end
        chk("rr_cnt", msg_cnt, 3);
        chk("rr_pba_end", pba, 0);

        // Masked vector 1 stays pending until unmasked
        cfg_wr(1, CFG_DATA, 32'h101);
        pulse(6'b000010);
        seen = 0;
        repeat (20) begin
            if (wr_valid) seen++;
            step();
        end
        chk("mask_no_send", seen, 0);
        chk("mask_pba", pba, 6'b000010);
        cfg_wr(1, CFG_CTRL, 0);
        chk("unmask_vld_c1", wr_valid, 0);
        step();
        chk("unmask_vld_c2", wr_valid, 1);
        chk("unmask_vec", wr_vec, 1);
        step();
        chk("unmask_cnt", msg_cnt, 4);
        chk("unmask_pba", pba, 0);

        // Backpressure with table rewrite, then re-request on the handshake edge
        wr_ready = 1'b0;
        pulse(6'b000100);
        step();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp_vld%0d", i), wr_valid, 1);
            chk($sformatf("bp_data%0d", i), wr_data, 32'h102);
            chk($sformatf("bp_vec%0d", i), wr_vec, 2);
            if (i == 0) begin
                cfg_wr_en = 1'b1;
                cfg_idx   = 3'd2;
                cfg_sel   = CFG_DATA;
                cfg_wdata = 32'h0000_DEAD;
            end
            step();
            cfg_wr_en = 1'b0;
        end
        wr_ready = 1'b1;
        intr_req = 6'b000100;
        step();
        intr_req = '0;
        chk("hs_vld", wr_valid, 0);
        chk("hs_pba", pba, 6'b000100);
        chk("hs_cnt", msg_cnt, 5);
        step();
        chk("resend_vld", wr_valid, 1);
        chk("resend_vec", wr_vec, 2);
        chk("resend_data", wr_data, 32'h0000_DEAD);
        step();
        chk("resend_cnt", msg_cnt, 6);
        chk("resend_pba", pba, 0);

        // Address alignment and out-of-range table writes
        cfg_wr(0, CFG_ADDR_LO, 32'h0000_1003);
        cfg_wr(0, CFG_DATA, 32'hCAFE_0000);
        cfg_wr(NV, CFG_DATA, 32'h1234_5678);
        cfg_wr(NV, CFG_ADDR_LO, 32'h0000_7770);
        pulse(6'b000001);
        step();
        chk("align_vld", wr_valid, 1);
        chk("align_addr", wr_addr, 64'h0000_0000_0000_1000);
        chk("align_data", wr_data, 32'hCAFE_0000);
        step();
        chk("align_cnt", msg_cnt, 7);

        // Reset while a message is held in SEND
        wr_ready = 1'b0;
        pulse(6'b000001);
        step();
        chk("pre_rst_vld", wr_valid, 1);
        intr_req = 6'b100100;
        step();
        intr_req = '0;
        chk("pre_rst_pba", pba, 6'b100101);
        rst = 1'b1;
        step();
        chk("midrst_vld", wr_valid, 0);
        chk("midrst_pba", pba, 0);
        chk("midrst_cnt", msg_cnt, 0);
        rst = 1'b0;
        wr_ready = 1'b1;
        pulse(6'b000001);
        seen = 0;
        repeat (4) begin
            if (wr_valid) seen++;
            step();
        end
        chk("midrst_masks", seen, 0);
        chk("midrst_pba_after", pba, 6'b000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
